// File: rtl/data_ram_ctl.sv
// Single-port 32-bit data RAM with byte/half/word access, one-cycle load latency and valid/ready handshakes.
// Optional macro DATA_RAM_ALIGN_CHK_EN rejects misaligned half/word accesses with rsp_err.
module data_ram_ctl #(
  parameter int DEPTH_LOG2 = 10,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic {IDLE, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [1:0]            w_lane;
  logic [31:0]           w_word;
  logic [31:0]           w_shift;
  logic [15:0]           w_half;
  logic                  w_illegal;
  logic [3:0]            w_be;
  logic [31:0]           w_wlanes;
  logic [31:0]           w_load;
  logic                  w_unused;

  assign w_idx    = req_addr[DEPTH_LOG2+1:2];
  assign w_lane   = req_addr[1:0];
  assign w_word   = r_mem[w_idx];
  assign w_unused = ^req_addr;

  // Ready is forced low during reset so nothing is accepted while rst is held.
  assign req_ready = rst && ((r_state == IDLE) || rsp_ready);
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  always_comb begin
    w_illegal = (req_size == 2'b11);
`ifdef DATA_RAM_ALIGN_CHK_EN
    if ((req_size == 2'b01) && w_lane[0])
      w_illegal = 1'b1;
    if ((req_size == 2'b10) && (w_lane != 2'b00))
      w_illegal = 1'b1;
`endif
  end

  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = req_wdata;
    case (req_size)
      2'b00: begin
        w_be     = 4'b0001 << w_lane;
        w_wlanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{req_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_shift = w_word >> {w_lane, 3'b000};
  assign w_half  = w_lane[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load = 32'h0;
    case (req_size)
      2'b00:   w_load = req_sign ? {{24{w_shift[7]}}, w_shift[7:0]} : {24'h0, w_shift[7:0]};
      2'b01:   w_load = req_sign ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      2'b10:   w_load = w_word;
      default: w_load = 32'h0;
    endcase
  end

  // Memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_accept && req_we && !w_illegal) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i])
          r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RESP;
      RESP: begin
        if (w_accept)
          w_next = RESP;
        else if (rsp_ready)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_rdata <= (req_we || w_illegal) ? 32'h0 : w_load;
      r_err   <= w_illegal;
    end
  end

endmodule

// File: tb/tb_data_ram_ctl.sv
// Scoreboard bench for data_ram_ctl: stimulus pushes expected responses, a monitor pops and compares.
module tb_data_ram_ctl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  data_ram_ctl #(.DEPTH_LOG2(10), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_sign  (req_sign),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each consumed response and checks stability during stalls.
  initial begin
    logic        stalled;
    logic [31:0] held_d;
    logic        held_e;
    exp_t        e;
    stalled = 1'b0;
    held_d  = 32'h0;
    held_e  = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (rst && rsp_valid) begin
        if (stalled) begin
          chk("stall_rdata_stable", rsp_rdata, held_d);
          chk("stall_err_stable", {31'h0, rsp_err}, {31'h0, held_e});
        end
        if (!rsp_ready) begin
          chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
          stalled = 1'b1;
          held_d  = rsp_rdata;
          held_e  = rsp_err;
        end else begin
          stalled = 1'b0;
          if (q.size() == 0) begin
            chk("unexpected_response", 32'h1, 32'h0);
          end else begin
            e = q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.d);
            chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.e});
          end
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic send(input logic we, input logic [1:0] size, input logic sign,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_d, input logic exp_e);
    int n;
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_sign  = sign;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'h0, 32'h1);
      req_valid = 1'b0;
      return;
    end
    e.d = exp_d;
    e.e = exp_e;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'b00;
    req_sign  = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("reset_req_ready", {31'h0, req_ready}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // word store/load with latency check
    send(1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, 32'h0, 1'b0);
    idle();
    send(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h11223344, 1'b0);
    #1 chk("load_latency_valid", {31'h0, rsp_valid}, 32'h1);
    idle();

    // byte lanes and extension
    send(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000AB, 32'h0, 1'b0);
    send(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'hFFFFFFAB, 1'b0);
    send(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h000000AB, 1'b0);
    send(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hAB223344, 1'b0);

    // half lanes
    send(1'b1, 2'b01, 1'b0, 32'h102, 32'h00008001, 32'h0, 1'b0);
    send(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'hFFFF8001, 1'b0);
    send(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h80013344, 1'b0);
    send(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h00008001, 1'b0);
    send(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h00000033, 1'b0);
    send(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h00003344, 1'b0);
    // address wrap: 0x1100 aliases 0x100 in a 1024-word RAM
    send(1'b0, 2'b10, 1'b0, 32'h1100, 32'h0, 32'h80013344, 1'b0);

    // back-to-back loads with a mid-stream stall
    send(1'b1, 2'b10, 1'b0, 32'h200, 32'h0A0A0A0A, 32'h0, 1'b0);
    send(1'b1, 2'b10, 1'b0, 32'h204, 32'h0B0B0B0B, 32'h0, 1'b0);
    send(1'b1, 2'b10, 1'b0, 32'h208, 32'h0C0C0C0C, 32'h0, 1'b0);
    send(1'b1, 2'b10, 1'b0, 32'h20C, 32'h0D0D0D0D, 32'h0, 1'b0);
    send(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h0A0A0A0A, 1'b0);
    send(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 32'h0B0B0B0B, 1'b0);
    rsp_ready = 1'b0;
    fork
      begin
        repeat (3) @(negedge clk);
        rsp_ready = 1'b1;
      end
    join_none
    send(1'b0, 2'b10, 1'b0, 32'h208, 32'h0, 32'h0C0C0C0C, 1'b0);
    send(1'b0, 2'b10, 1'b0, 32'h20C, 32'h0, 32'h0D0D0D0D, 1'b0);
    idle();

    // misaligned word store and illegal size
`ifdef DATA_RAM_ALIGN_CHK_EN
    send(1'b1, 2'b10, 1'b0, 32'h101, 32'hDEADBEEF, 32'h0, 1'b1);
    send(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h80013344, 1'b0);
`else
    send(1'b1, 2'b10, 1'b0, 32'h101, 32'hDEADBEEF, 32'h0, 1'b0);
    send(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);
`endif
    send(1'b0, 2'b11, 1'b1, 32'h200, 32'h0, 32'h0, 1'b1);
    send(1'b1, 2'b11, 1'b0, 32'h200, 32'hFFFFFFFF, 32'h0, 1'b1);
    send(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h0A0A0A0A, 1'b0);

    // reset while a response is stalled
    send(1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D, 32'h0, 1'b0);
    idle();
    rsp_ready = 1'b0;
    send(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'hCAFEF00D, 1'b0);
    req_valid = 1'b0;
    #1 chk("pre_reset_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    #4;
    rst = 1'b0;
    #1;
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    if (q.size() > 0) void'(q.pop_back());
    repeat (2) @(negedge clk);
    rst       = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    send(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'hCAFEF00D, 1'b0);
    send(1'b0, 2'b00, 1'b1, 32'h20F, 32'h0, 32'h0000000D, 1'b0);
    idle();

    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", q.size(), 32'h0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
